pe_arr_seq: RTL and testbench

//  Job sequencer for the ROWS x COLS systolic PE array. Accepts a job command (K operand steps),

---
 rtl/pe_arr_pkg.sv | 20 ++
 rtl/pe_skew_line.sv | 25 ++
 rtl/pe_arr_seq.sv | 153 +++++++++++++++
 tb/tb_pe_arr_seq.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_arr_pkg.sv
// Shared types and helpers for the PE array job sequencer.
package pe_arr_pkg;

  localparam int unsigned LANE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  // Cycles for the last injected beat to reach and settle in the far corner PE.
  function automatic int unsigned drain_cycles(input int unsigned rows,
                                               input int unsigned cols,
                                               input int unsigned pe_lat);
    return (rows + cols - 1) * pe_lat + ((rows > cols) ? rows : cols);
  endfunction

endpackage

// File: rtl/pe_skew_line.sv
// Fixed-depth delay line with asynchronous clear; one per array lane to build the diagonal skew.
module pe_skew_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] pipe_q [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned s = 0; s < DEPTH; s++) pipe_q[s] <= '0;
    end else begin
      pipe_q[0] <= d_i;
      for (int unsigned s = 1; s < DEPTH; s++) pipe_q[s] <= pipe_q[s-1];
    end
  end

  assign q_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/pe_arr_seq.sv
// Job sequencer for a ROWS x COLS systolic PE array: streams K skewed beats, fires, flushes, hands off.
// Define PE_ARR_SEQ_PERF_EN to add the perf_busy_cyc / perf_stall_cyc counters.
module pe_arr_seq
  import pe_arr_pkg::*;
#(
  parameter int unsigned ROWS   = 16,
  parameter int unsigned COLS   = 16,
  parameter int unsigned KW     = 16,
  parameter int unsigned PE_LAT = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [KW-1:0]            cmd_k,
  input  logic                     op_valid,
  output logic                     op_ready,
  input  logic [ROWS*LANE_W-1:0]   op_w,
  input  logic [COLS*LANE_W-1:0]   op_a,
  output logic                     arr_fire,
  output logic [ROWS*LANE_W-1:0]   arr_w,
  output logic [COLS*LANE_W-1:0]   arr_a,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic                     busy
`ifdef PE_ARR_SEQ_PERF_EN
  ,
  output logic [31:0]              perf_busy_cyc,
  output logic [31:0]              perf_stall_cyc
`endif
);

  localparam int unsigned DRAIN = drain_cycles(ROWS, COLS, PE_LAT);
  localparam int unsigned DW    = $clog2(DRAIN + 1);

  seq_state_e             state_q;
  logic [KW-1:0]          k_q;
  logic [DW-1:0]          drain_q;
  logic                   first_q;
  logic                   cmd_ready_q;
  logic                   op_ready_q;
  logic                   fire_q;
  logic                   res_valid_q;
  logic                   busy_q;
  logic                   op_acc;
  logic [ROWS*LANE_W-1:0] inj_w_d;
  logic [COLS*LANE_W-1:0] inj_a_d;

  // Cycles without an accepted beat inject zeros so weights and activations stay aligned.
  assign op_acc  = op_valid & op_ready_q;
  assign inj_w_d = op_acc ? op_w : '0;
  assign inj_a_d = op_acc ? op_a : '0;

  for (genvar i = 0; i < ROWS; i++) begin : g_w_lane
    pe_skew_line #(.DEPTH(1 + i), .W(LANE_W)) u_skew (
      .clk (clk),
      .rst (rst),
      .d_i (inj_w_d[i*LANE_W +: LANE_W]),
      .q_o (arr_w[i*LANE_W +: LANE_W])
    );
  end

  for (genvar j = 0; j < COLS; j++) begin : g_a_lane
    pe_skew_line #(.DEPTH(1 + j), .W(LANE_W)) u_skew (
      .clk (clk),
      .rst (rst),
      .d_i (inj_a_d[j*LANE_W +: LANE_W]),
      .q_o (arr_a[j*LANE_W +: LANE_W])
    );
  end

  // Job FSM; all handshake outputs are registered alongside the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      k_q         <= '0;
      drain_q     <= '0;
      first_q     <= 1'b0;
      cmd_ready_q <= 1'b1;
      op_ready_q  <= 1'b0;
      fire_q      <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      fire_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            state_q     <= ST_LOAD;
            k_q         <= cmd_k;
            first_q     <= 1'b1;
            cmd_ready_q <= 1'b0;
            op_ready_q  <= (cmd_k != '0);
            busy_q      <= 1'b1;
          end
        end
        ST_LOAD: begin
          fire_q  <= first_q;
          first_q <= 1'b0;
          if (op_acc) k_q <= k_q - KW'(1);
          // Leave on the cycle the final beat is taken (or at once for an empty job).
          if ((k_q == '0) || (op_acc && (k_q == KW'(1)))) begin
            state_q    <= ST_FLUSH;
            op_ready_q <= 1'b0;
            drain_q    <= DW'(DRAIN);
          end
        end
        ST_FLUSH: begin
          if (drain_q == DW'(1)) begin
            state_q     <= ST_DONE;
            res_valid_q <= 1'b1;
          end else begin
            drain_q <= drain_q - DW'(1);
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            state_q     <= ST_IDLE;
            res_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign op_ready  = op_ready_q;
  assign arr_fire  = fire_q;
  assign res_valid = res_valid_q;
  assign busy      = busy_q;

`ifdef PE_ARR_SEQ_PERF_EN
  logic [31:0] perf_busy_q;
  logic [31:0] perf_stall_q;

  // Busy time includes the command-accept cycle; both counters wrap freely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_busy_q  <= '0;
      perf_stall_q <= '0;
    end else begin
      if (busy_q || (cmd_valid && cmd_ready_q)) perf_busy_q <= perf_busy_q + 32'd1;
      if (op_ready_q && !op_valid) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end

  assign perf_busy_cyc  = perf_busy_q;
  assign perf_stall_cyc = perf_stall_q;
`endif

endmodule

// File: tb/tb_pe_arr_seq.sv
// Self-checking bench for pe_arr_seq (ROWS=COLS=4, PE_LAT=1); PE_ARR_SEQ_PERF_EN adds counter checks.
module tb_pe_arr_seq;

  localparam int unsigned ROWS   = 4;
  localparam int unsigned COLS   = 4;
  localparam int unsigned KW     = 16;
  localparam int unsigned PE_LAT = 1;
  localparam int          DRAIN  = (ROWS + COLS - 1) * PE_LAT + ((ROWS > COLS) ? ROWS : COLS);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [15:0] cmd_k = '0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [31:0] op_w = '0;
  logic [31:0] op_a = '0;
  logic        arr_fire;
  logic [31:0] arr_w;
  logic [31:0] arr_a;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic        busy;
`ifdef PE_ARR_SEQ_PERF_EN
  logic [31:0] perf_busy_cyc;
  logic [31:0] perf_stall_cyc;
  logic [31:0] pb0, ps0;
`endif

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  pe_arr_seq #(.ROWS(ROWS), .COLS(COLS), .KW(KW), .PE_LAT(PE_LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_k     (cmd_k),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_w      (op_w),
    .op_a      (op_a),
    .arr_fire  (arr_fire),
    .arr_w     (arr_w),
    .arr_a     (arr_a),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .busy      (busy)
`ifdef PE_ARR_SEQ_PERF_EN
    ,
    .perf_busy_cyc  (perf_busy_cyc),
    .perf_stall_cyc (perf_stall_cyc)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: job phase (0 idle, 1 load, 2 flush, 3 done) plus a history of injected beats.
  int          m_phase, m_left, m_flush;
  bit          m_first, m_fire, m_acc;
  logic [31:0] hw [8];
  logic [31:0] ha [8];
  logic [31:0] ew, ea;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_phase = 0; m_left = 0; m_flush = 0; m_first = 0; m_fire = 0;
      for (int d = 0; d < 8; d++) begin hw[d] = '0; ha[d] = '0; end
    end else begin
      m_acc = (m_phase == 1) && (m_left > 0) && op_valid;
      for (int d = 7; d > 0; d--) begin hw[d] = hw[d-1]; ha[d] = ha[d-1]; end
      hw[0] = m_acc ? op_w : '0;
      ha[0] = m_acc ? op_a : '0;
      m_fire = (m_phase == 1) && m_first;
      case (m_phase)
        0: if (cmd_valid) begin m_phase = 1; m_left = int'(cmd_k); m_first = 1; end
        1: begin
          m_first = 0;
          if (m_acc) m_left--;
          if (m_left == 0) begin m_phase = 2; m_flush = DRAIN; end
        end
        2: begin m_flush--; if (m_flush == 0) m_phase = 3; end
        3: if (res_ready) m_phase = 0;
        default: m_phase = 0;
      endcase
    end
  end

  // Lane i must show the beat injected i+1 edges ago.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        ew[8*i +: 8] = hw[i][8*i +: 8];
        ea[8*i +: 8] = ha[i][8*i +: 8];
      end
      chk("arr_w",     64'(arr_w),     64'(ew));
      chk("arr_a",     64'(arr_a),     64'(ea));
      chk("arr_fire",  64'(arr_fire),  64'(m_fire));
      chk("busy",      64'(busy),      64'(m_phase != 0));
      chk("cmd_ready", 64'(cmd_ready), 64'(m_phase == 0));
      chk("op_ready",  64'(op_ready),  64'((m_phase == 1) && (m_left > 0)));
      chk("res_valid", 64'(res_valid), 64'(m_phase == 3));
    end
  end

  // Per-job observations and a 4x4 output-stationary array fed from the DUT outputs.
  int        r_fire_t, r_fire_n, r_l0_t, r_l0b_t, r_l3_t, r_opr_n, r_res_t, r_res_n, r_cmdr_n;
  int        cacc [4][4];
  int        expc [4][4];
  logic [7:0] wh [4][4];
  logic [7:0] ah [4][4];

  function automatic void gen_beat(input int idx, input bit rnd,
                                   output logic [31:0] w, output logic [31:0] a);
    if (rnd) begin
      w = $urandom;
      a = $urandom;
    end else begin
      w = {4{8'(idx + 1)}};
      a = w;
    end
  endfunction

  task automatic run_job(input int k, input logic [15:0] vmask, input int hold, input bit rnd);
    int          bi, h;
    bit          done, rr, pend;
    logic [31:0] bw, ba;
    r_fire_t = -1; r_l0_t = -1; r_l0b_t = -1; r_l3_t = -1; r_res_t = -1;
    r_fire_n = 0; r_opr_n = 0; r_res_n = 0; r_cmdr_n = 0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        cacc[i][j] = 0; expc[i][j] = 0; wh[i][j] = '0; ah[i][j] = '0;
      end
    bi = 0; h = 0; done = 0; rr = 0; pend = 0;
    gen_beat(0, rnd, bw, ba);
    @(negedge clk);
    for (int w = 0; w < 20 && !cmd_ready; w++) @(negedge clk);
    cmd_valid = 1'b1;
    cmd_k     = 16'(k);
    for (int n = 1; n <= 80 && !done; n++) begin
      @(negedge clk);
      if (pend) begin bi++; gen_beat(bi, rnd, bw, ba); end
      if (n == 1) cmd_valid = 1'b0;
      for (int d = 3; d > 0; d--)
        for (int l = 0; l < 4; l++) begin wh[d][l] = wh[d-1][l]; ah[d][l] = ah[d-1][l]; end
      for (int l = 0; l < 4; l++) begin wh[0][l] = arr_w[8*l +: 8]; ah[0][l] = arr_a[8*l +: 8]; end
      for (int i = 0; i < 4; i++)
        for (int j = 0; j < 4; j++) cacc[i][j] += int'(wh[j][i]) * int'(ah[i][j]);
      if (arr_fire) begin r_fire_n++; if (r_fire_t < 0) r_fire_t = n; end
      if (arr_w[7:0] == 8'h01 && r_l0_t < 0) r_l0_t = n;
      if (arr_w[7:0] == 8'h02 && r_l0b_t < 0) r_l0b_t = n;
      if (arr_w[31:24] == 8'h01 && r_l3_t < 0) r_l3_t = n;
      if (op_ready) r_opr_n++;
      if (rr) begin
        done = 1'b1;
        res_ready = 1'b0;
      end else if (res_valid) begin
        r_res_n++;
        if (r_res_t < 0) r_res_t = n;
        if (cmd_ready) r_cmdr_n++;
        if (h >= hold) begin res_ready = 1'b1; rr = 1'b1; cmd_valid = 1'b0; end
        else begin cmd_valid = 1'b1; cmd_k = 16'd7; end
        h++;
      end
      op_valid = (n <= 16) ? vmask[n-1] : (bi < k);
      op_w     = bw;
      op_a     = ba;
      pend     = op_valid && (bi < k);
      if (pend)
        for (int i = 0; i < 4; i++)
          for (int j = 0; j < 4; j++) expc[i][j] += int'(bw[8*i +: 8]) * int'(ba[8*j +: 8]);
    end
    op_valid = 1'b0; cmd_valid = 1'b0; res_ready = 1'b0;
    chk("job_done", 64'(done), 64'(1));
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) chk("array_acc", 64'(cacc[i][j]), 64'(expc[i][j]));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d checks", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy",      64'(busy),      64'(0));
    chk("rst_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("rst_op_ready",  64'(op_ready),  64'(0));
    chk("rst_res_valid", 64'(res_valid), 64'(0));
    chk("rst_fire",      64'(arr_fire),  64'(0));
    chk("rst_arr_w",     64'(arr_w),     64'(0));

    // k=3, beats 1,2,3 back to back
    run_job(3, 16'hFFFF, 0, 1'b0);
    chk("k3_fire_t",  64'(r_fire_t), 64'(2));
    chk("k3_fire_n",  64'(r_fire_n), 64'(1));
    chk("k3_lane0_t", 64'(r_l0_t),   64'(2));
    chk("k3_lane3_t", 64'(r_l3_t),   64'(5));
    chk("k3_load",    64'(r_opr_n),  64'(3));
    chk("k3_res_t",   64'(r_res_t),  64'(1 + 3 + 11));
    chk("k3_c00",     64'(cacc[0][0]), 64'(14));
    chk("k3_c33",     64'(cacc[3][3]), 64'(14));

    // k=2 with two stall cycles between beats
    run_job(2, 16'h0009, 0, 1'b0);
    chk("k2s_load",    64'(r_opr_n),  64'(4));
    chk("k2s_lane0_t", 64'(r_l0_t),   64'(2));
    chk("k2s_lane0b",  64'(r_l0b_t),  64'(5));
    chk("k2s_fire_n",  64'(r_fire_n), 64'(1));
    chk("k2s_res_t",   64'(r_res_t),  64'(1 + 4 + 11));
    chk("k2s_c03",     64'(cacc[0][3]), 64'(5));

    // k=0: fire once, nothing accepted even with op_valid high
    run_job(0, 16'hFFFF, 0, 1'b0);
    chk("k0_fire_t", 64'(r_fire_t), 64'(2));
    chk("k0_fire_n", 64'(r_fire_n), 64'(1));
    chk("k0_load",   64'(r_opr_n),  64'(0));
    chk("k0_lane0",  64'(r_l0_t),   64'(-1));
    chk("k0_res_t",  64'(r_res_t),  64'(1 + 1 + 11));
    chk("k0_c22",    64'(cacc[2][2]), 64'(0));

    // DONE held for 10 cycles while a new command is offered
    run_job(1, 16'hFFFF, 10, 1'b0);
    chk("hold_res_t",  64'(r_res_t),  64'(13));
    chk("hold_res_n",  64'(r_res_n),  64'(11));
    chk("hold_cmdr_n", 64'(r_cmdr_n), 64'(0));
    @(negedge clk);
    chk("hold_no_new_job", 64'(busy), 64'(0));

    // k=3 with two stalls (perf counters when enabled)
`ifdef PE_ARR_SEQ_PERF_EN
    pb0 = perf_busy_cyc;
    ps0 = perf_stall_cyc;
`endif
    run_job(3, 16'h0013, 0, 1'b0);
    chk("k3s_load",  64'(r_opr_n),    64'(5));
    chk("k3s_res_t", 64'(r_res_t),    64'(1 + 5 + 11));
    chk("k3s_c12",   64'(cacc[1][2]), 64'(14));
`ifdef PE_ARR_SEQ_PERF_EN
    chk("perf_busy",  64'(perf_busy_cyc - pb0),  64'(1 + 5 + 11 + 1));
    chk("perf_stall", 64'(perf_stall_cyc - ps0), 64'(2));
`endif

    // random data and valid pattern, checked by the model and array sums
    run_job(4, 16'($urandom), 2, 1'b1);

    // reset in the middle of LOAD after two beats
    @(negedge clk);
    cmd_valid = 1'b1; cmd_k = 16'd5;
    @(negedge clk);
    cmd_valid = 1'b0; op_valid = 1'b1; op_w = {4{8'h11}}; op_a = {4{8'h22}};
    @(negedge clk);
    op_w = {4{8'h33}}; op_a = {4{8'h44}};
    @(negedge clk);
    chk("prerst_lane0", 64'(arr_w[7:0]), 64'(8'h33));
    chk("prerst_busy",  64'(busy),       64'(1));
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    op_valid = 1'b0;
    @(negedge clk);
    chk("midrst_busy",      64'(busy),      64'(0));
    chk("midrst_cmd_ready", 64'(cmd_ready), 64'(1));
    chk("midrst_op_ready",  64'(op_ready),  64'(0));
    chk("midrst_arr_w",     64'(arr_w),     64'(0));
    chk("midrst_arr_a",     64'(arr_a),     64'(0));
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
